// File: rtl/biriscv_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module  : biriscv_divider_pkg
// Purpose : Shared types and instruction match/mask constants for the RV32M
//           DIV/DIVU/REM/REMU out-of-pipe divider.
// Contents: div_state_t  - divider FSM state encoding
//           INST_*       - match/mask pairs for the four divide opcodes
//           is_divrem()  - decode helper (any of DIV/DIVU/REM/REMU)
// Revision: 1.0 - initial release
// ============================================================================
package biriscv_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } div_state_t;

   // Individual encodings: funct7=0000001, major opcode=0110011.
   localparam logic [31:0] INST_DIV       = 32'h0200_4033;
   localparam logic [31:0] INST_DIV_MASK  = 32'hfe00_707f;
   localparam logic [31:0] INST_DIVU      = 32'h0200_5033;
   localparam logic [31:0] INST_DIVU_MASK = 32'hfe00_707f;
   localparam logic [31:0] INST_REM       = 32'h0200_6033;
   localparam logic [31:0] INST_REM_MASK  = 32'hfe00_707f;
   localparam logic [31:0] INST_REMU      = 32'h0200_7033;
   localparam logic [31:0] INST_REMU_MASK = 32'hfe00_707f;

   // All four share funct3[2]=1, so a single compare ignoring funct3[1:0]
   // recognises the whole group.
   localparam logic [31:0] INST_DIVREM_MATCH = 32'h0200_4033;
   localparam logic [31:0] INST_DIVREM_MASK  = 32'hfe00_407f;

   function automatic logic is_divrem(input logic [31:0] inst);
      return (inst & INST_DIVREM_MASK) == INST_DIVREM_MATCH;
   endfunction

endpackage : biriscv_divider_pkg
`default_nettype wire

// File: rtl/biriscv_divider.sv
`default_nettype none
// ============================================================================
// Module  : biriscv_divider
// Purpose : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//           Fixed latency: a start sampled at edge N raises writeback_valid_o
//           at edge N+33; the result is held until the next start or flush.
// Ports   : clk_i               - clock
//           rst_ni              - asynchronous active-low reset
//           opcode_valid_i      - issue strobe
//           opcode_opcode_i     - instruction word (funct3 selects op)
//           opcode_ra_operand_i - dividend (rs1)
//           opcode_rb_operand_i - divisor (rs2)
//           flush_i             - squash any operation in flight
//           busy_o              - iteration in progress
//           writeback_valid_o   - result valid (level, held)
//           writeback_value_o   - result value
// Revision: 1.0 - initial release
// ============================================================================
module biriscv_divider
   import biriscv_divider_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        opcode_valid_i,
   input  logic [31:0] opcode_opcode_i,
   input  logic [31:0] opcode_ra_operand_i,
   input  logic [31:0] opcode_rb_operand_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        writeback_valid_o,
   output logic [31:0] writeback_value_o
);

   // Issue stage: the strobe and operands are registered at the sampling
   // edge, and the divider proper launches on the following edge. This keeps
   // the inputs off any output path and lines up the valid drop with E1.
   logic        start_q,      start_d;
   logic        req_signed_q, req_signed_d;
   logic        req_rem_q,    req_rem_d;
   logic [31:0] req_a_q,      req_a_d;
   logic [31:0] req_b_q,      req_b_d;

   // Iteration state
   div_state_t  state_q,      state_d;
   logic [4:0]  count_q,      count_d;
   logic [31:0] quot_q,       quot_d;
   logic [31:0] rem_q,        rem_d;
   logic [31:0] divisor_q,    divisor_d;
   logic        invert_q_q,   invert_q_d;
   logic        invert_r_q,   invert_r_d;
   logic        rem_sel_q,    rem_sel_d;
   logic [31:0] result_q,     result_d;

   // Step datapath
   logic [32:0] shifted;
   logic [32:0] trial;
   logic [31:0] step_quot;
   logic [31:0] step_rem;

   always_comb begin
      // Partial remainder is always below the divisor, so after the shift it
      // fits in 33 bits; bit 32 of the trial result is the borrow.
      shifted = {rem_q, quot_q[31]};
      trial   = shifted - {1'b0, divisor_q};
      if (!trial[32]) begin
         step_rem  = trial[31:0];
         step_quot = {quot_q[30:0], 1'b1};
      end else begin
         step_rem  = shifted[31:0];
         step_quot = {quot_q[30:0], 1'b0};
      end
   end

   always_comb begin
      start_d      = opcode_valid_i & is_divrem(opcode_opcode_i) & ~flush_i;
      req_signed_d = req_signed_q;
      req_rem_d    = req_rem_q;
      req_a_d      = req_a_q;
      req_b_d      = req_b_q;
      state_d      = state_q;
      count_d      = count_q;
      quot_d       = quot_q;
      rem_d        = rem_q;
      divisor_d    = divisor_q;
      invert_q_d   = invert_q_q;
      invert_r_d   = invert_r_q;
      rem_sel_d    = rem_sel_q;
      result_d     = result_q;

      if (opcode_valid_i) begin
         req_signed_d = ~opcode_opcode_i[12];
         req_rem_d    = opcode_opcode_i[13];
         req_a_d      = opcode_ra_operand_i;
         req_b_d      = opcode_rb_operand_i;
      end

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            // A start arriving while busy is dropped.
            if (start_q) begin
               state_d    = ST_BUSY;
               count_d    = 5'd0;
               quot_d     = (req_signed_q && req_a_q[31]) ? -req_a_q : req_a_q;
               divisor_d  = (req_signed_q && req_b_q[31]) ? -req_b_q : req_b_q;
               rem_d      = 32'd0;
               // Divide by zero keeps the all-ones quotient unsigned.
               invert_q_d = req_signed_q & (req_a_q[31] ^ req_b_q[31]) &
                            (req_b_q != 32'd0);
               invert_r_d = req_signed_q & req_a_q[31];
               rem_sel_d  = req_rem_q;
            end
         end
         ST_BUSY: begin
            quot_d  = step_quot;
            rem_d   = step_rem;
            count_d = count_q + 5'd1;
            if (count_q == 5'd31) begin
               state_d = ST_DONE;
               if (rem_sel_q) begin
                  result_d = invert_r_q ? -step_rem : step_rem;
               end else begin
                  result_d = invert_q_q ? -step_quot : step_quot;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush_i) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         start_q      <= 1'b0;
         req_signed_q <= 1'b0;
         req_rem_q    <= 1'b0;
         req_a_q      <= 32'd0;
         req_b_q      <= 32'd0;
         state_q      <= ST_IDLE;
         count_q      <= 5'd0;
         quot_q       <= 32'd0;
         rem_q        <= 32'd0;
         divisor_q    <= 32'd0;
         invert_q_q   <= 1'b0;
         invert_r_q   <= 1'b0;
         rem_sel_q    <= 1'b0;
         result_q     <= 32'd0;
      end else begin
         start_q      <= start_d;
         req_signed_q <= req_signed_d;
         req_rem_q    <= req_rem_d;
         req_a_q      <= req_a_d;
         req_b_q      <= req_b_d;
         state_q      <= state_d;
         count_q      <= count_d;
         quot_q       <= quot_d;
         rem_q        <= rem_d;
         divisor_q    <= divisor_d;
         invert_q_q   <= invert_q_d;
         invert_r_q   <= invert_r_d;
         rem_sel_q    <= rem_sel_d;
         result_q     <= result_d;
      end
   end

   assign busy_o            = (state_q == ST_BUSY);
   assign writeback_valid_o = (state_q == ST_DONE);
   assign writeback_value_o = result_q;

endmodule : biriscv_divider
`default_nettype wire
